div_unit: RTL and testbench

// - Multi-cycle radix-2 restoring integer divider in the EXE stage; executes DIV/DIVU for HI/LO.
// - Drives the EXE-stage stall request into the stall control unit, freezing the whole pipeline (stall=4'b1111) while busy.
// - The dividing instruction stays in EXE with div_start held high until the result is ready.

---
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for DIV/DIVU in EXE.
// Requests a full pipeline stall while a division is in flight; results go to LO/HI.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic              div_cancel,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              stallreq_div,
  output logic              div_ready,
  output logic [DATA_W-1:0] div_quotient,
  output logic [DATA_W-1:0] div_remainder
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic              qNeg_q, qNeg_d;
  logic              rNeg_q, rNeg_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic              aNeg, bNeg;
  logic [DATA_W-1:0] absA, absB;
  logic [DATA_W:0]   remShift, trial;
  logic [DATA_W-1:0] stepRem, stepQuo;
  logic [DATA_W-1:0] fixedQuo, fixedRem;

  // Operand magnitudes: only DIV takes absolute values; 2^31 stays correct as an unsigned magnitude.
  always_comb begin
    aNeg = div_signed & dividend[DATA_W-1];
    bNeg = div_signed & divisor[DATA_W-1];
    absA = aNeg ? ({DATA_W{1'b0}} - dividend) : dividend;
    absB = bNeg ? ({DATA_W{1'b0}} - divisor) : divisor;
  end

  // One restoring step: shift {rem,quo} left, subtract with a spare bit so the top bit is the borrow.
  always_comb begin
    remShift = {rem_q, quo_q[DATA_W-1]};
    trial    = remShift - {1'b0, dvsr_q};
    stepRem  = trial[DATA_W] ? remShift[DATA_W-1:0] : trial[DATA_W-1:0];
    stepQuo  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    fixedQuo = qNeg_q ? ({DATA_W{1'b0}} - stepQuo) : stepQuo;
    fixedRem = rNeg_q ? ({DATA_W{1'b0}} - stepRem) : stepRem;
  end

  // Next-state logic: cancel aborts from any state and never touches the held result registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    qNeg_d      = qNeg_q;
    rNeg_d      = rNeg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (div_cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            rem_d  = '0;
            quo_d  = absA;
            dvsr_d = absB;
            cnt_d  = '0;
            qNeg_d = aNeg ^ bNeg;
            rNeg_d = aNeg;
            if (divisor == '0) begin
              quotient_d  = '1;
              remainder_d = dividend;
              state_d     = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            quotient_d  = fixedQuo;
            remainder_d = fixedRem;
            state_d     = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset clears everything including the visible result.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      qNeg_q      <= 1'b0;
      rNeg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      qNeg_q      <= qNeg_d;
      rNeg_q      <= rNeg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Stall the pipeline while a divide is pending; release in DONE so the instruction can leave EXE.
  always_comb begin
    stallreq_div  = div_start & ~div_cancel & (state_q != S_DONE);
    div_ready     = (state_q == S_DONE);
    div_quotient  = quotient_q;
    div_remainder = remainder_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divide sequences checked every cycle against an arithmetic reference,
// plus a literal table of hand-computed results and stall lengths for each completed divide.
module tb_div_unit;

  localparam int W            = 32;
  localparam int NUM_OPS      = 10;
  localparam int READY_BUDGET = 100;

  logic         clock = 1'b0;
  logic         reset;
  logic         divStart;
  logic         divSigned;
  logic         divCancel;
  logic [W-1:0] dividendIn;
  logic [W-1:0] divisorIn;
  logic         stallReq;
  logic         divReady;
  logic [W-1:0] quotientOut;
  logic [W-1:0] remainderOut;

  int errors   = 0;
  int checks   = 0;
  int timeouts = 0;
  bit checkEn  = 1'b0;
  bit finishReq = 1'b0;

  bit           mDone = 1'b0;
  int           mWait = 0;
  logic [W-1:0] mQ    = '0;
  logic [W-1:0] mR    = '0;
  logic [W-1:0] pendQ = '0;
  logic [W-1:0] pendR = '0;

  logic [W-1:0] litQ [0:NUM_OPS-1] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0,
                                       32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd14, 32'd3, 32'd3};
  logic [W-1:0] litR [0:NUM_OPS-1] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000,
                                       32'd5, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0};
  int litStall [0:NUM_OPS-1] = '{33, 33, 33, 33, 33, 1, 1, 33, 33, 33};

  div_unit #(.DATA_W(W)) dut (
    .cpu_clk_50M   (clock),
    .cpu_rst       (reset),
    .div_start     (divStart),
    .div_signed    (divSigned),
    .div_cancel    (divCancel),
    .dividend      (dividendIn),
    .divisor       (divisorIn),
    .stallreq_div  (stallReq),
    .div_ready     (divReady),
    .div_quotient  (quotientOut),
    .div_remainder (remainderOut)
  );

  // 50 MHz-style free-running clock.
  always #5 clock = ~clock;

  // Reference quotient: truncating division, all-ones for a zero divisor, INT_MIN/-1 saturates to INT_MIN.
  function automatic logic [W-1:0] goldenQ(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] intMin;
    intMin = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return '1;
    if (!sgn) return a / b;
    if (a == intMin && b == '1) return intMin;
    return W'($signed(a) / $signed(b));
  endfunction

  // Reference remainder: sign follows the dividend, raw dividend for a zero divisor.
  function automatic logic [W-1:0] goldenR(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] intMin;
    intMin = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return a;
    if (!sgn) return a % b;
    if (a == intMin && b == '1) return '0;
    return W'($signed(a) % $signed(b));
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    divStart   = start;
    divSigned  = sgn;
    dividendIn = a;
    divisorIn  = b;
  endtask

  task automatic waitReady();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < READY_BUDGET && !seen; i++) begin
      @(negedge clock);
      if (divReady) seen = 1'b1;
    end
    if (!seen) begin
      timeouts++;
      $display("[TB] FAIL ready_timeout: no div_ready within %0d cycles", READY_BUDGET);
    end
  endtask

  task automatic runDivide(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    applyStimulus(1'b1, sgn, a, b);
    waitReady();
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
  endtask

  // Cycle-level reference: a divide is 1 start cycle plus W busy cycles, zero divisor finishes at once.
  initial begin : modelProc
    forever begin
      @(posedge clock);
      if (reset) begin
        mDone = 1'b0;
        mWait = 0;
        mQ    = '0;
        mR    = '0;
      end else if (divCancel) begin
        mDone = 1'b0;
        mWait = 0;
      end else if (mDone) begin
        mDone = 1'b0;
      end else if (mWait > 0) begin
        mWait--;
        if (mWait == 0) begin
          mDone = 1'b1;
          mQ    = pendQ;
          mR    = pendR;
        end
      end else if (divStart) begin
        pendQ = goldenQ(divSigned, dividendIn, divisorIn);
        pendR = goldenR(divSigned, dividendIn, divisorIn);
        if (divisorIn == '0) begin
          mDone = 1'b1;
          mQ    = pendQ;
          mR    = pendR;
        end else begin
          mWait = W;
        end
      end
    end
  end

  // Compare process: every mid-cycle, outputs against the reference; at each ready, against the literal table.
  initial begin : compareProc
    int  stallRun;
    int  readyCount;
    logic expStall;
    stallRun   = 0;
    readyCount = 0;
    forever begin
      @(negedge clock);
      if (finishReq) begin
        checkOutput("ready_count", W'(readyCount), W'(NUM_OPS));
        checkOutput("timeouts", W'(timeouts), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (checkEn) begin
        expStall = divStart & ~divCancel & ~mDone;
        checkOutput("stallreq_div", W'(stallReq), W'(expStall));
        checkOutput("div_ready", W'(divReady), W'(mDone));
        checkOutput("div_quotient", quotientOut, mQ);
        checkOutput("div_remainder", remainderOut, mR);
        if (stallReq) stallRun++;
        if (reset || divCancel) stallRun = 0;
        if (divReady) begin
          if (readyCount < NUM_OPS) begin
            checkOutput("lit_quotient", quotientOut, litQ[readyCount]);
            checkOutput("lit_remainder", remainderOut, litR[readyCount]);
            checkOutput("lit_stall_cycles", W'(stallRun), W'(litStall[readyCount]));
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_ready: got ready #%0d, expected only %0d", readyCount + 1, NUM_OPS);
          end
          readyCount++;
          stallRun = 0;
        end
      end
    end
  end

  // Directed sequence: plain and signed divides, overflow, zero divisor, cancel, back-to-back, reset.
  initial begin : stimulusProc
    reset     = 1'b1;
    divCancel = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;
    checkEn = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    runDivide(1'b0, 32'd100, 32'd7);
    runDivide(1'b1, 32'hFFFF_FFF9, 32'd2);
    runDivide(1'b1, 32'd7, 32'hFFFF_FFFE);
    runDivide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runDivide(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    runDivide(1'b0, 32'd5, 32'd0);
    runDivide(1'b1, 32'hFFFF_FFF9, 32'd0);

    $display("[TB] cancel in busy cycle 10");
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #1 divCancel = 1'b1;
    @(posedge clock); #1;
    divCancel = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] back-to-back divides");
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
    waitReady();
    @(posedge clock); #1;
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd3);
    waitReady();
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    @(posedge clock); #1;

    $display("[TB] reset in busy cycle 20");
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;

    runDivide(1'b0, 32'd9, 32'd3);
    finishReq = 1'b1;
  end

endmodule
